mmio_fifo_combiner: RTL and testbench



---
 rtl/mmio_fifo_combiner.sv | 191 +++++++++++++++++++
 tb/tb_mmio_fifo_combiner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_combiner.sv
// mmio_fifo_combiner
//   Register-mapped block with two input FIFOs (A, B) and one output FIFO (Y).
//   A combiner pops one entry from A and one from B and pushes f(A,B) into Y,
//   where f is selected by the MODE register (OR, AND, XOR, ADD mod 2^DATA_W).
//
// Optional feature (compile-time macro MMIO_COMBINER_OVF_CNT_EN):
//   When defined, address 7 reads an 8-bit saturating counter of dropped
//   A/B writes and empty Y_DATA reads. The counter clears when address 7 is read.
//   When undefined, address 7 reads 0.
//
// Ports:
//   CLK, RST        single rising-edge clock, asynchronous active-high reset
//   write_address   register address for writes
//   write_data      write payload (DATA_W bits)
//   write_en        write strobe, takes effect at the CLK edge when write_rdy=1
//   write_rdy       write accepted (1 from the first edge after reset)
//   read_address    register address for reads
//   read_en         read strobe, side effects at the CLK edge when read_rdy=1
//   read_data       combinational read value for read_address
//   read_rdy        read accepted (1 from the first edge after reset)
//
// Handshake: a write (read) transfers on a rising CLK edge where write_en
// (read_en) and write_rdy (read_rdy) are both 1. read_data is valid whenever
// read_rdy=1. Write and read ports are independent.
//
// Register map:
//   0 A_STATUS (R) A not full     1 A_DATA (W) push A
//   2 B_STATUS (R) B not full     3 B_DATA (W) push B
//   4 Y_STATUS (R) Y not empty    5 Y_DATA (R) Y head, pop on read
//   6 MODE (R/W) bits[1:0]        7 OVF (R) overflow/underflow counter
module mmio_fifo_combiner #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [2:0]        read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] ADDR_A_STATUS = 3'd0;
  localparam logic [2:0] ADDR_A_DATA   = 3'd1;
  localparam logic [2:0] ADDR_B_STATUS = 3'd2;
  localparam logic [2:0] ADDR_B_DATA   = 3'd3;
  localparam logic [2:0] ADDR_Y_STATUS = 3'd4;
  localparam logic [2:0] ADDR_Y_DATA   = 3'd5;
  localparam logic [2:0] ADDR_MODE     = 3'd6;
  localparam logic [2:0] ADDR_OVF      = 3'd7;

  logic              rdy_q;
  logic [1:0]        mode;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];
  logic [DATA_W-1:0] y_mem [DEPTH];
  logic [PTR_W-1:0]  a_wr, a_rd, b_wr, b_rd, y_wr, y_rd;
  logic [CNT_W-1:0]  a_cnt, b_cnt, y_cnt;

  logic              wr_acc, rd_acc;
  logic              a_full, b_full, y_full;
  logic              a_empty, b_empty, y_empty;
  logic              a_push, b_push, y_pop, comb;
  logic [DATA_W-1:0] comb_val;
  logic [DATA_W-1:0] ovf_val;
  logic [DATA_W-1:0] rd_val;

  assign wr_acc  = write_en & rdy_q;
  assign rd_acc  = read_en & rdy_q;

  // All full/empty decisions below use the pre-edge counts.
  assign a_full  = (a_cnt == FULL_CNT);
  assign b_full  = (b_cnt == FULL_CNT);
  assign y_full  = (y_cnt == FULL_CNT);
  assign a_empty = (a_cnt == '0);
  assign b_empty = (b_cnt == '0);
  assign y_empty = (y_cnt == '0);

  assign a_push  = wr_acc && (write_address == ADDR_A_DATA) && !a_full;
  assign b_push  = wr_acc && (write_address == ADDR_B_DATA) && !b_full;
  assign y_pop   = rd_acc && (read_address == ADDR_Y_DATA) && !y_empty;

  // A host pop of Y frees a slot on the same edge, so a full Y does not
  // stall the combiner when it is being read.
  assign comb    = !a_empty && !b_empty && (!y_full || y_pop);

  always_comb begin
    comb_val = '0;
    case (mode)
      2'd0:    comb_val = a_mem[a_rd] | b_mem[b_rd];
      2'd1:    comb_val = a_mem[a_rd] & b_mem[b_rd];
      2'd2:    comb_val = a_mem[a_rd] ^ b_mem[b_rd];
      default: comb_val = a_mem[a_rd] + b_mem[b_rd];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode  <= RESET_MODE;
      a_wr  <= '0;
      a_rd  <= '0;
      b_wr  <= '0;
      b_rd  <= '0;
      y_wr  <= '0;
      y_rd  <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (wr_acc && (write_address == ADDR_MODE)) mode <= write_data[1:0];
      if (a_push) a_wr <= a_wr + PTR_W'(1);
      if (b_push) b_wr <= b_wr + PTR_W'(1);
      if (comb) begin
        a_rd <= a_rd + PTR_W'(1);
        b_rd <= b_rd + PTR_W'(1);
        y_wr <= y_wr + PTR_W'(1);
      end
      if (y_pop) y_rd <= y_rd + PTR_W'(1);
      a_cnt <= a_cnt + CNT_W'(a_push) - CNT_W'(comb);
      b_cnt <= b_cnt + CNT_W'(b_push) - CNT_W'(comb);
      y_cnt <= y_cnt + CNT_W'(comb) - CNT_W'(y_pop);
    end
  end

  // Storage is not reset; the pointers and counts define what is valid.
  always_ff @(posedge CLK) begin
    if (a_push) a_mem[a_wr] <= write_data;
    if (b_push) b_mem[b_wr] <= write_data;
    if (comb)   y_mem[y_wr] <= comb_val;
  end

`ifdef MMIO_COMBINER_OVF_CNT_EN
  logic       drop_ev, under_ev;
  logic [1:0] ovf_events;
  logic [8:0] ovf_sum;
  logic [7:0] ovf_cnt;

  assign drop_ev    = wr_acc && (((write_address == ADDR_A_DATA) && a_full) ||
                                 ((write_address == ADDR_B_DATA) && b_full));
  assign under_ev   = rd_acc && (read_address == ADDR_Y_DATA) && y_empty;
  assign ovf_events = {1'b0, drop_ev} + {1'b0, under_ev};
  assign ovf_sum    = {1'b0, ovf_cnt} + {7'd0, ovf_events};

  // A read of the counter restarts it from this edge's events.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                         ovf_cnt <= '0;
    else if (rd_acc && (read_address == ADDR_OVF))   ovf_cnt <= {6'd0, ovf_events};
    else if (ovf_sum[8])                             ovf_cnt <= 8'hFF;
    else                                             ovf_cnt <= ovf_sum[7:0];
  end

  assign ovf_val = DATA_W'(ovf_cnt);
`else
  assign ovf_val = '0;
`endif

  always_comb begin
    rd_val = '0;
    if (rdy_q) begin
      case (read_address)
        ADDR_A_STATUS: rd_val[0] = !a_full;
        ADDR_B_STATUS: rd_val[0] = !b_full;
        ADDR_Y_STATUS: rd_val[0] = !y_empty;
        ADDR_Y_DATA:   if (!y_empty) rd_val = y_mem[y_rd];
        ADDR_MODE:     rd_val = DATA_W'(mode);
        ADDR_OVF:      rd_val = ovf_val;
        default:       rd_val = '0;
      endcase
    end
  end

  assign read_data = rd_val;
  assign write_rdy = rdy_q;
  assign read_rdy  = rdy_q;

endmodule

// File: tb/tb_mmio_fifo_combiner.sv
// tb_mmio_fifo_combiner
//   Directed and randomized stimulus for mmio_fifo_combiner, checked against a
//   queue-based reference model. Inputs change after the falling edge; outputs
//   are sampled 1 time unit later, well away from the rising edge.
module tb_mmio_fifo_combiner;

  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam logic [1:0] RESET_MODE = 2'd1;
`ifdef MMIO_COMBINER_OVF_CNT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic              CLK;
  logic              RST;
  logic [2:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [2:0]        read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;

  mmio_fifo_combiner #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .RESET_MODE(RESET_MODE)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .write_address(write_address),
    .write_data(write_data),
    .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address),
    .read_en(read_en),
    .read_data(read_data),
    .read_rdy(read_rdy)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];
  logic [DATA_W-1:0] qy[$];
  int m_mode;
  int m_ovf;

  function automatic logic [DATA_W-1:0] combine(input int md, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    int sum;
    case (md)
      0: return a | b;
      1: return a & b;
      2: return a ^ b;
      default: begin
        sum = int'(a) + int'(b);
        return DATA_W'(sum % (1 << DATA_W));
      end
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [2:0] ra);
    case (ra)
      3'd0: return DATA_W'(qa.size() < DEPTH);
      3'd2: return DATA_W'(qb.size() < DEPTH);
      3'd4: return DATA_W'(qy.size() > 0);
      3'd5: return (qy.size() > 0) ? qy[0] : '0;
      3'd6: return DATA_W'(m_mode);
      3'd7: return OVF_ON ? DATA_W'(m_ovf) : '0;
      default: return '0;
    endcase
  endfunction

  // One rising edge of the block, computed from the pre-edge model state.
  task automatic model_edge(input bit we, input logic [2:0] wa, input logic [DATA_W-1:0] wd,
                            input bit re, input logic [2:0] ra);
    int ev;
    bit pop_y, fire, a_ok, b_ok;
    logic [DATA_W-1:0] av, bv;
    ev = 0;
    pop_y = re && (ra == 3'd5) && (qy.size() > 0);
    if (re && (ra == 3'd5) && (qy.size() == 0)) ev++;
    a_ok = we && (wa == 3'd1) && (qa.size() < DEPTH);
    b_ok = we && (wa == 3'd3) && (qb.size() < DEPTH);
    if (we && (wa == 3'd1) && !a_ok) ev++;
    if (we && (wa == 3'd3) && !b_ok) ev++;
    fire = (qa.size() > 0) && (qb.size() > 0) && ((qy.size() < DEPTH) || pop_y);
    if (pop_y) void'(qy.pop_front());
    if (fire) begin
      av = qa.pop_front();
      bv = qb.pop_front();
      qy.push_back(combine(m_mode, av, bv));
    end
    if (a_ok) qa.push_back(wd);
    if (b_ok) qb.push_back(wd);
    if (we && (wa == 3'd6)) m_mode = int'(wd[1:0]);
    if (re && (ra == 3'd7)) m_ovf = ev;
    else m_ovf = (m_ovf + ev > 255) ? 255 : m_ovf + ev;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge. want: >=0 fixed value, -1 model value, -2 no check.
  task automatic cycle(input bit we, input logic [2:0] wa, input logic [DATA_W-1:0] wd,
                       input bit re, input logic [2:0] ra, input int want, input string tag);
    write_en = we;
    write_address = wa;
    write_data = wd;
    read_en = re;
    read_address = ra;
    #1;
    if (want >= 0) check(tag, read_data, DATA_W'(want));
    else if (want == -1) check(tag, read_data, model_read(ra));
    @(posedge CLK);
    model_edge(we, wa, wd, re, ra);
    @(negedge CLK);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [DATA_W-1:0] wd);
    cycle(1'b1, wa, wd, 1'b0, 3'd0, -2, "");
  endtask

  task automatic rd(input logic [2:0] ra, input int want, input string tag);
    cycle(1'b0, 3'd0, '0, 1'b1, ra, want, tag);
  endtask

  task automatic apply_reset(input string tag);
    write_en = 1'b0;
    read_en = 1'b0;
    read_address = 3'd0;
    #2 RST = 1'b1;
    #1;
    check({tag, "_write_rdy"}, DATA_W'(write_rdy), '0);
    check({tag, "_read_rdy"}, DATA_W'(read_rdy), '0);
    check({tag, "_read_data"}, read_data, '0);
    qa.delete();
    qb.delete();
    qy.delete();
    m_mode = int'(RESET_MODE);
    m_ovf = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check({tag, "_rdy_before_edge"}, DATA_W'(read_rdy), '0);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_write_rdy_up"}, DATA_W'(write_rdy), DATA_W'(1));
    check({tag, "_read_rdy_up"}, DATA_W'(read_rdy), DATA_W'(1));
    rd(3'd0, 1, {tag, "_a_status"});
    rd(3'd4, 0, {tag, "_y_status"});
    rd(3'd6, int'(RESET_MODE), {tag, "_mode"});
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] wmap[10];
  logic [2:0] rmap[10];

  initial begin
    RST = 1'b0;
    write_en = 1'b0;
    write_address = 3'd0;
    write_data = '0;
    read_en = 1'b0;
    read_address = 3'd0;
    m_mode = int'(RESET_MODE);
    m_ovf = 0;
    wmap = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd6, 3'd0, 3'd5, 3'd7};
    rmap = '{3'd5, 3'd5, 3'd5, 3'd4, 3'd0, 3'd2, 3'd6, 3'd7, 3'd1, 3'd3};

    apply_reset("init");

    // OR with two-edge latency
    wr(3'd6, 8'd0);
    wr(3'd1, 8'h0F);
    wr(3'd3, 8'hF0);
    rd(3'd4, 0, "lat_edge1");
    rd(3'd4, 1, "lat_edge2");
    rd(3'd5, 8'hFF, "or_result");
    rd(3'd4, 0, "y_empty_after_pop");

    // ADD with carry dropped, then XOR
    wr(3'd6, 8'd3);
    wr(3'd1, 8'hC8);
    wr(3'd3, 8'h50);
    rd(3'd4, 0, "add_wait");
    rd(3'd5, 8'h18, "add_result");
    wr(3'd6, 8'd2);
    wr(3'd1, 8'hAA);
    wr(3'd3, 8'hFF);
    rd(3'd4, 0, "xor_wait");
    rd(3'd5, 8'h55, "xor_result");

    // MODE written on the combine edge: the old mode (OR) still applies
    wr(3'd6, 8'd0);
    wr(3'd1, 8'h0C);
    wr(3'd3, 8'h0A);
    cycle(1'b1, 3'd6, 8'd1, 1'b1, 3'd4, 0, "mode_edge_wait");
    rd(3'd5, 8'h0E, "mode_next_edge");
    rd(3'd6, 1, "mode_readback");

    // Depth: fill A, drop the 5th, then drain through B (XOR)
    wr(3'd6, 8'd2);
    rd(3'd7, -1, "ovf_clear_pre");
    for (int i = 0; i < 4; i++) wr(3'd1, DATA_W'(8'h11 * (i + 1)));
    rd(3'd0, 0, "a_full_status");
    wr(3'd1, 8'h99);
    rd(3'd0, 0, "a_full_after_drop");
    for (int i = 0; i < 4; i++) wr(3'd3, DATA_W'(i + 1));
    rd(3'd4, 1, "y_filling");
    rd(3'd2, 1, "b_not_full");

    // Y full, A/B stalled; pop Y while writing B: pop and combine push together
    wr(3'd1, 8'h5A);
    wr(3'd1, 8'h3C);
    wr(3'd3, 8'hFF);
    cycle(1'b1, 3'd3, 8'h0F, 1'b1, 3'd5, 8'h10, "full_pop_push");
    rd(3'd5, 8'h20, "order_1");
    rd(3'd5, 8'h30, "order_2");
    rd(3'd5, 8'h40, "order_3");
    rd(3'd5, 8'hA5, "order_4");
    rd(3'd5, 8'h33, "order_5");
    rd(3'd4, 0, "y_drained");
    rd(3'd5, 0, "y_empty_read");

    // Overflow counter: 2 dropped writes + 1 empty Y read
    rd(3'd7, -1, "ovf_clear");
    for (int i = 0; i < 4; i++) wr(3'd1, DATA_W'(i));
    wr(3'd1, 8'hE1);
    wr(3'd1, 8'hE2);
    rd(3'd5, 0, "ovf_empty_y");
    rd(3'd7, OVF_ON ? 3 : 0, "ovf_count");
    rd(3'd7, 0, "ovf_cleared");
    for (int i = 0; i < 4; i++) wr(3'd3, 8'hFF);
    rd(3'd4, -1, "ovf_drain_wait");
    for (int i = 0; i < 4; i++) rd(3'd5, int'(8'hFF ^ DATA_W'(i)), $sformatf("ovf_drain_%0d", i));

    // Randomized traffic against the model, with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic [2:0] wa, ra;
      bit we, re;
      if (i == 200) begin
        wr(3'd1, 8'h77);
        wr(3'd3, 8'h88);
        apply_reset("mid");
      end
      wa = wmap[$urandom_range(0, 9)];
      ra = rmap[$urandom_range(0, 9)];
      we = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 3) != 0);
      cycle(we, wa, DATA_W'($urandom), re, ra, -1, $sformatf("rand%0d_addr%0d", i, ra));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
